// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with a valid/ready handshake on both sides.
// Define ALU_OVF_STICKY_EN to add the sticky overflow flag (o_ovf_sticky / i_ovf_clr).
module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
`ifdef ALU_OVF_STICKY_EN
    ,
    output logic             o_ovf_sticky,
    input  logic             i_ovf_clr
`endif
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SLT = 3'b110,
        OP_EQ  = 3'b111
    } op_e;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_bc;
    logic             r_s1_cin;
    op_e              r_s1_op;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;

    op_e              w_op;
    logic             w_adv2;
    logic             w_in_fire;
    logic             w_b_inv;
    logic [WIDTH:0]   w_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;

    assign w_op       = op_e'(i_op);
    assign w_adv2     = !r_out_valid || i_out_ready;
    assign o_in_ready = !r_s1_valid || w_adv2;
    assign w_in_fire  = i_in_valid && o_in_ready;

    // Subtract, signed compare and equality all run through the adder as A + ~B + 1.
    assign w_b_inv = (w_op == OP_SUB) || (w_op == OP_SLT) || (w_op == OP_EQ);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_bc    <= '0;
            r_s1_cin   <= 1'b0;
            r_s1_op    <= OP_ADD;
        end else begin
            if (o_in_ready) begin
                r_s1_valid <= i_in_valid;
            end
            if (w_in_fire) begin
                r_s1_a   <= i_a;
                r_s1_bc  <= w_b_inv ? ~i_b : i_b;
                r_s1_cin <= w_b_inv;
                r_s1_op  <= w_op;
            end
        end
    end

    assign w_sum     = {1'b0, r_s1_a} + {1'b0, r_s1_bc} + {{WIDTH{1'b0}}, r_s1_cin};
    assign w_add_ovf = (r_s1_a[WIDTH-1] == r_s1_bc[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (r_s1_op)
            OP_ADD, OP_SUB: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = w_add_ovf;
            end
            OP_NOT:  w_result = ~r_s1_a;
            OP_AND:  w_result = r_s1_a & r_s1_bc;
            OP_OR:   w_result = r_s1_a | r_s1_bc;
            OP_XOR:  w_result = r_s1_a ^ r_s1_bc;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
            OP_EQ:   w_result = {{(WIDTH-1){1'b0}}, (w_sum[WIDTH-1:0] == '0)};
            default: w_result = '0;
        endcase
    end

    // Stage 2 only reloads when the consumer is not stalling it, so a stalled beat holds stable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b1;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result   <= w_result;
                r_carry    <= w_carry;
                r_overflow <= w_ovf;
                r_zero     <= (w_result == '0);
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_carry     = r_carry;
    assign o_overflow  = r_overflow;
    assign o_zero      = r_zero;

`ifdef ALU_OVF_STICKY_EN
    logic r_ovf_sticky;

    // A set event on the same edge as a clear request takes priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (r_out_valid && i_out_ready && r_overflow) begin
            r_ovf_sticky <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign o_ovf_sticky = r_ovf_sticky;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against a queue-based reference model.
// Covers the ALU_OVF_STICKY_EN build when that macro is defined.
module tb_alu_pipe;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
`ifdef ALU_OVF_STICKY_EN
    logic         ovf_sticky;
    logic         ovf_clr;
    logic         stickyExp;
`endif

    int   errors;
    int   checks;
    int   cycle;
    exp_t expQ[$];
    exp_t e;
    exp_t pushE;
    logic [W+2:0] pk;

    logic [2:0]   stallOps[3];
    logic [W-1:0] stallAs[3];
    logic [W-1:0] stallBs[3];
    logic [W-1:0] gotRes;
    logic         gotC;
    logic         gotV;
    logic         gotZ;
    int           gotLat;
    int           idx;
    logic [W-1:0] held;
    logic [6:0]   validTrace;

    alu_pipe #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_op        (op),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_carry     (carry),
        .o_overflow  (overflow),
        .o_zero      (zero)
`ifdef ALU_OVF_STICKY_EN
        ,
        .o_ovf_sticky(ovf_sticky),
        .i_ovf_clr   (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {carry, overflow, zero, result} from plain integer arithmetic.
    function automatic logic [W+2:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int ux, uy, sx, sy, r;
        int maxS, minS;
        logic c, v;
        ux   = int'(x);
        uy   = int'(y);
        sx   = x[W-1] ? ux - (1 << W) : ux;
        sy   = y[W-1] ? uy - (1 << W) : uy;
        maxS = (1 << (W-1)) - 1;
        minS = -(1 << (W-1));
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'd0: begin
                r = ux + uy;
                c = (r >= (1 << W));
                v = ((sx + sy) > maxS) || ((sx + sy) < minS);
            end
            3'd1: begin
                r = ux - uy;
                c = (ux >= uy);
                v = ((sx - sy) > maxS) || ((sx - sy) < minS);
            end
            3'd2:    r = ~ux;
            3'd3:    r = ux & uy;
            3'd4:    r = ux | uy;
            3'd5:    r = ux ^ uy;
            3'd6:    r = (sx < sy) ? 1 : 0;
            default: r = (ux == uy) ? 1 : 0;
        endcase
        r = r & ((1 << W) - 1);
        return {c, v, (r == 0), W'(r)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
    endtask

    // Sends one beat into an empty pipeline and captures the first result presented.
    task automatic sendOne(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(1'b1, o, x, y);
        @(posedge clk); #1;
        in_valid = 1'b0;
        gotLat = 0;
        gotRes = '0; gotC = 1'b0; gotV = 1'b0; gotZ = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (out_valid) begin
                gotLat = k;
                gotRes = result; gotC = carry; gotV = overflow; gotZ = zero;
                break;
            end
        end
    endtask

    // Scoreboard: every cycle, compare presented outputs with the oldest accepted beat.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ.delete();
`ifdef ALU_OVF_STICKY_EN
            stickyExp = 1'b0;
`endif
        end else begin
            cycle++;
`ifdef ALU_OVF_STICKY_EN
            checkOutput("ovfSticky", 32'(ovf_sticky), 32'(stickyExp));
            if (ovf_clr) stickyExp = 1'b0;
`endif
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousOutput", 32'd1, 32'd0);
                end else begin
                    e = expQ[0];
                    checkOutput("earlyOutput", 32'(cycle - e.cyc >= 2), 32'd1);
                    checkOutput("result", 32'(result), 32'(e.res));
                    checkOutput("carry", 32'(carry), 32'(e.c));
                    checkOutput("overflow", 32'(overflow), 32'(e.v));
                    checkOutput("zero", 32'(zero), 32'(e.z));
                    if (out_ready) begin
`ifdef ALU_OVF_STICKY_EN
                        if (e.v) stickyExp = 1'b1;
`endif
                        void'(expQ.pop_front());
                    end
                end
            end else if (expQ.size() != 0 && (cycle - expQ[0].cyc) >= 2) begin
                checkOutput("missingOutput", 32'd0, 32'd1);
            end
            if (in_valid && in_ready) begin
                pk        = model(op, a, b);
                pushE.c   = pk[W+2];
                pushE.v   = pk[W+1];
                pushE.z   = pk[W];
                pushE.res = pk[W-1:0];
                pushE.cyc = cycle;
                expQ.push_back(pushE);
            end
        end
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0; out_ready = 1'b1;
        errors = 0; checks = 0; cycle = 0;
        applyStimulus(1'b0, 3'd0, '0, '0);
`ifdef ALU_OVF_STICKY_EN
        ovf_clr = 1'b0;
`endif
        stallOps = '{3'd0, 3'd0, 3'd5};
        stallAs  = '{4'd1, 4'd2, 4'd5};
        stallBs  = '{4'd1, 4'd3, 4'd6};

        // Model pinned against hand-computed values.
        checkOutput("modelAdd7p1", 32'(model(3'd0, 4'd7, 4'd1)), 32'h28);
        checkOutput("modelSub3m5", 32'(model(3'd1, 4'd3, 4'd5)), 32'h0E);
        checkOutput("modelSub5m5", 32'(model(3'd1, 4'd5, 4'd5)), 32'h50);
        checkOutput("modelSltM8", 32'(model(3'd6, 4'd8, 4'd7)), 32'h01);
        checkOutput("modelSlt7", 32'(model(3'd6, 4'd7, 4'd8)), 32'h10);
        checkOutput("modelEq9", 32'(model(3'd7, 4'd9, 4'd9)), 32'h01);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstResult", 32'(result), 32'd0);
        checkOutput("rstCarry", 32'(carry), 32'd0);
        checkOutput("rstOverflow", 32'(overflow), 32'd0);
        checkOutput("rstZero", 32'(zero), 32'd1);
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        sendOne(3'd0, 4'd7, 4'd1);
        checkOutput("add7p1Lat", 32'(gotLat), 32'd2);
        checkOutput("add7p1Res", 32'(gotRes), 32'h8);
        checkOutput("add7p1Flags", {29'd0, gotC, gotV, gotZ}, 32'b010);
        sendOne(3'd1, 4'd3, 4'd5);
        checkOutput("sub3m5Res", 32'(gotRes), 32'hE);
        checkOutput("sub3m5Flags", {29'd0, gotC, gotV, gotZ}, 32'b000);
        sendOne(3'd1, 4'd5, 4'd5);
        checkOutput("sub5m5Res", 32'(gotRes), 32'h0);
        checkOutput("sub5m5Flags", {29'd0, gotC, gotV, gotZ}, 32'b101);
        sendOne(3'd6, 4'd8, 4'd7);
        checkOutput("sltM8Res", 32'(gotRes), 32'h1);
        sendOne(3'd6, 4'd7, 4'd8);
        checkOutput("slt7Res", 32'(gotRes), 32'h0);
        sendOne(3'd7, 4'd9, 4'd9);
        checkOutput("eq9Res", 32'(gotRes), 32'h1);
        checkOutput("eq9Zero", 32'(gotZ), 32'd0);
        sendOne(3'd2, 4'd15, 4'd3);
        checkOutput("notFRes", 32'(gotRes), 32'h0);
        checkOutput("notFZero", 32'(gotZ), 32'd1);

        // Back-to-back adds must flow with no bubbles.
        validTrace = '0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            if (c < 4) applyStimulus(1'b1, 3'd0, W'(3 * c + 1), W'(c + 2));
            else in_valid = 1'b0;
            @(negedge clk);
            if (c < 4) checkOutput("streamInReady", 32'(in_ready), 32'd1);
            validTrace[c] = out_valid;
        end
        checkOutput("streamValidTrace", 32'(validTrace), 32'b0111100);

        // Stall: consumer blocks for 4 cycles while three beats are offered.
        idx = 0;
        held = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 4);
            if (idx < 3) applyStimulus(1'b1, stallOps[idx], stallAs[idx], stallBs[idx]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (c == 2) held = result;
            if (c == 3) begin
                checkOutput("stallAccepted", 32'(idx), 32'd2);
                checkOutput("stallInReady", 32'(in_ready), 32'd0);
                checkOutput("stallHeld", 32'(result), 32'(held));
                checkOutput("stallHeldValue", 32'(result), 32'h2);
            end
        end
        checkOutput("stallAllAccepted", 32'(idx), 32'd3);
        checkOutput("stallDrained", 32'(expQ.size()), 32'd0);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, 3'd0, W'(i + 2), W'(i + 5));
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        checkOutput("midRstZero", 32'(zero), 32'd1);
        checkOutput("midRstResult", 32'(result), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("postRstInReady", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("postRstNoStale", 32'(out_valid), 32'd0);
        end

`ifdef ALU_OVF_STICKY_EN
        checkOutput("stickyAfterRst", 32'(ovf_sticky), 32'd0);
        sendOne(3'd0, 4'd7, 4'd1);
        @(negedge clk);
        checkOutput("stickySet", 32'(ovf_sticky), 32'd1);
        sendOne(3'd0, 4'd1, 4'd1);
        @(negedge clk);
        checkOutput("stickySurvives", 32'(ovf_sticky), 32'd1);
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        checkOutput("stickyCleared", 32'(ovf_sticky), 32'd0);
`endif

        // Randomized traffic with random backpressure; scoreboard does the checking.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(3) != 0);
            op        = 3'($urandom);
            a         = W'($urandom);
            b         = W'($urandom);
            if ($urandom_range(3) == 0) a = ($urandom_range(1) == 0) ? W'(1 << (W-1)) : W'((1 << (W-1)) - 1);
            if ($urandom_range(3) == 0) b = ($urandom_range(1) == 0) ? W'(0) : W'((1 << W) - 1);
            out_ready = ($urandom_range(3) != 0);
`ifdef ALU_OVF_STICKY_EN
            ovf_clr   = ($urandom_range(15) == 0);
`endif
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef ALU_OVF_STICKY_EN
        ovf_clr   = 1'b0;
`endif
        for (int k = 0; k < 20 && (expQ.size() != 0 || out_valid); k++) @(negedge clk);
        checkOutput("drainQueue", 32'(expQ.size()), 32'd0);
        checkOutput("drainOutValid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
